// File: rtl/radiant_event_buf_sched.sv
// Trigger-to-buffer scheduler: accepts triggers into a ring of digitizer buffers,
// sequences each digitization and tracks occupancy, dead time and lost triggers.
module radiant_event_buf_sched #(
    parameter int unsigned NBUF        = 4,
    parameter int unsigned DIG_TIMEOUT = 4095
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic                    trig_i,
    input  logic                    trig_type_i,
    input  logic [31:0]             trig_info_i,
    input  logic                    dig_done_i,
    input  logic                    readout_done_i,
    input  logic                    flush_i,
    input  logic                    clear_stats_i,
    output logic                    dig_start_o,
    output logic [$clog2(NBUF)-1:0] dig_buf_o,
    output logic                    event_o,
    output logic                    event_type_o,
    output logic [31:0]             event_info_o,
    output logic                    event_done_o,
    output logic                    busy_o,
    output logic [$clog2(NBUF):0]   pending_o,
    output logic                    timeout_o,
    output logic [31:0]             dead_count_o,
    output logic [15:0]             trig_lost_o
);

    localparam int unsigned BW = $clog2(NBUF);
    localparam int unsigned PW = BW + 1;
    localparam int unsigned TW = $clog2(DIG_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIGITIZE = 2'd1,
        ST_DONE     = 2'd2
    } state_e;

    state_e          state_q;
    logic [1:0]      sync_q;
    logic [BW-1:0]   wr_ptr_q;
    logic [BW-1:0]   rd_ptr_q;
    logic [PW-1:0]   pending_q;
    logic [TW-1:0]   timer_q;
    logic            event_q;
    logic            dig_start_q;
    logic            event_done_q;
    logic [BW-1:0]   dig_buf_q;
    logic            event_type_q;
    logic [31:0]     event_info_q;
    logic            timeout_q;
    logic [31:0]     dead_count_q;
    logic [15:0]     trig_lost_q;

    logic            busy_c;
    logic            accept_c;
    logic            readout_c;
    logic            tmo_hit_c;

    assign busy_c    = (state_q != ST_IDLE) || (pending_q == PW'(NBUF));
    assign accept_c  = sync_q[1] && (state_q == ST_IDLE) && trig_i && enable_i &&
                       (pending_q < PW'(NBUF)) && !flush_i;
    assign readout_c = readout_done_i && (pending_q != '0) && !flush_i;
    assign tmo_hit_c = (state_q == ST_DIGITIZE) && !dig_done_i && (timer_q == TW'(DIG_TIMEOUT));

    // Reset release is brought through two flops before accepts are allowed
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    // Scheduler FSM with registered event outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pending_q    <= '0;
            timer_q      <= '0;
            event_q      <= 1'b0;
            dig_start_q  <= 1'b0;
            event_done_q <= 1'b0;
            dig_buf_q    <= '0;
            event_type_q <= 1'b0;
            event_info_q <= '0;
        end else begin
            event_q      <= 1'b0;
            dig_start_q  <= 1'b0;
            event_done_q <= 1'b0;
            if (flush_i) begin
                state_q   <= ST_IDLE;
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                pending_q <= '0;
                timer_q   <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (accept_c) begin
                            state_q      <= ST_DIGITIZE;
                            timer_q      <= '0;
                            event_q      <= 1'b1;
                            dig_start_q  <= 1'b1;
                            dig_buf_q    <= wr_ptr_q;
                            event_type_q <= trig_type_i;
                            event_info_q <= trig_info_i;
                        end
                    end
                    ST_DIGITIZE: begin
                        if (dig_done_i || tmo_hit_c) begin
                            state_q <= ST_DONE;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    ST_DONE: begin
                        event_done_q <= 1'b1;
                        wr_ptr_q     <= wr_ptr_q + BW'(1);
                        state_q      <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase

                if (readout_c) begin
                    rd_ptr_q <= rd_ptr_q + BW'(1);
                end
                // Simultaneous accept and readout leave occupancy unchanged
                if (accept_c && !readout_c) begin
                    pending_q <= pending_q + PW'(1);
                end else if (!accept_c && readout_c) begin
                    pending_q <= pending_q - PW'(1);
                end
            end
        end
    end

    // Statistics; clear wins over any increment in the same cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timeout_q    <= 1'b0;
            dead_count_q <= '0;
            trig_lost_q  <= '0;
        end else if (clear_stats_i) begin
            timeout_q    <= 1'b0;
            dead_count_q <= '0;
            trig_lost_q  <= '0;
        end else begin
            if (tmo_hit_c && !flush_i) begin
                timeout_q <= 1'b1;
            end
            if (enable_i && busy_c) begin
                dead_count_q <= dead_count_q + 32'd1;
            end
            if (trig_i && enable_i && busy_c && (trig_lost_q != 16'hFFFF)) begin
                trig_lost_q <= trig_lost_q + 16'd1;
            end
        end
    end

    assign dig_start_o  = dig_start_q;
    assign dig_buf_o    = dig_buf_q;
    assign event_o      = event_q;
    assign event_type_o = event_type_q;
    assign event_info_o = event_info_q;
    assign event_done_o = event_done_q;
    assign busy_o       = busy_c;
    assign pending_o    = pending_q;
    assign timeout_o    = timeout_q;
    assign dead_count_o = dead_count_q;
    assign trig_lost_o  = trig_lost_q;

endmodule

// File: tb/tb_radiant_event_buf_sched.sv
// Bench for radiant_event_buf_sched: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based occupancy model.
module tb_radiant_event_buf_sched;

    localparam int NBUF = 4;
    localparam int TMO  = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        trig = 1'b0;
    logic        trig_type = 1'b0;
    logic [31:0] trig_info = 32'd0;
    logic        dig_done = 1'b0;
    logic        readout = 1'b0;
    logic        flush = 1'b0;
    logic        clear = 1'b0;

    logic        dig_start_o;
    logic [1:0]  dig_buf_o;
    logic        event_o;
    logic        event_type_o;
    logic [31:0] event_info_o;
    logic        event_done_o;
    logic        busy_o;
    logic [2:0]  pending_o;
    logic        timeout_o;
    logic [31:0] dead_count_o;
    logic [15:0] trig_lost_o;

    radiant_event_buf_sched #(
        .NBUF        (NBUF),
        .DIG_TIMEOUT (TMO)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .enable_i       (enable),
        .trig_i         (trig),
        .trig_type_i    (trig_type),
        .trig_info_i    (trig_info),
        .dig_done_i     (dig_done),
        .readout_done_i (readout),
        .flush_i        (flush),
        .clear_stats_i  (clear),
        .dig_start_o    (dig_start_o),
        .dig_buf_o      (dig_buf_o),
        .event_o        (event_o),
        .event_type_o   (event_type_o),
        .event_info_o   (event_info_o),
        .event_done_o   (event_done_o),
        .busy_o         (busy_o),
        .pending_o      (pending_o),
        .timeout_o      (timeout_o),
        .dead_count_o   (dead_count_o),
        .trig_lost_o    (trig_lost_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: occupied buffers as a queue of indices, digitization as an age count
    int          m_q[$];
    int          m_wr  = 0;
    bit          m_dig = 1'b0;
    bit          m_fin = 1'b0;
    int          m_age = 0;
    int          m_rdy = 0;
    bit          e_event = 1'b0;
    bit          e_start = 1'b0;
    bit          e_done  = 1'b0;
    bit          e_type  = 1'b0;
    bit          e_tmo   = 1'b0;
    int          e_buf   = 0;
    logic [31:0] e_info  = 32'd0;
    logic [31:0] e_dead  = 32'd0;
    int          e_lost  = 0;

    function automatic bit m_busy();
        return m_dig || m_fin || (m_q.size() == NBUF);
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_wr = 0; m_dig = 1'b0; m_fin = 1'b0; m_age = 0; m_rdy = 0;
            e_event = 1'b0; e_start = 1'b0; e_done = 1'b0; e_type = 1'b0; e_tmo = 1'b0;
            e_buf = 0; e_info = 32'd0; e_dead = 32'd0; e_lost = 0;
        end else begin
            bit bsy;
            bit acc;
            bit rd;
            bsy = m_busy();
            acc = (m_rdy >= 2) && !m_dig && !m_fin && trig && enable &&
                  (m_q.size() < NBUF) && !flush;
            rd  = readout && (m_q.size() > 0) && !flush;
            if (clear) begin
                e_dead = 32'd0; e_lost = 0; e_tmo = 1'b0;
            end else begin
                if (enable && bsy) e_dead = e_dead + 32'd1;
                if (trig && enable && bsy && e_lost < 65535) e_lost++;
                if (m_dig && !dig_done && m_age == TMO && !flush) e_tmo = 1'b1;
            end
            e_event = 1'b0; e_start = 1'b0; e_done = 1'b0;
            if (flush) begin
                m_q.delete();
                m_wr = 0; m_dig = 1'b0; m_fin = 1'b0;
            end else begin
                if (m_fin) begin
                    e_done = 1'b1;
                    m_wr   = (m_wr + 1) % NBUF;
                    m_fin  = 1'b0;
                end else if (m_dig) begin
                    if (dig_done || m_age == TMO) begin
                        m_dig = 1'b0;
                        m_fin = 1'b1;
                    end else begin
                        m_age++;
                    end
                end
                if (rd) void'(m_q.pop_front());
                if (acc) begin
                    m_q.push_back(m_wr);
                    e_event = 1'b1; e_start = 1'b1;
                    e_buf = m_wr; e_type = trig_type; e_info = trig_info;
                    m_dig = 1'b1; m_age = 0;
                end
            end
            if (m_rdy < 2) m_rdy++;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("event_o",      32'(event_o),      32'(e_event));
            check("dig_start_o",  32'(dig_start_o),  32'(e_start));
            check("dig_buf_o",    32'(dig_buf_o),    32'(e_buf));
            check("event_type_o", 32'(event_type_o), 32'(e_type));
            check("event_info_o", event_info_o,      e_info);
            check("event_done_o", 32'(event_done_o), 32'(e_done));
            check("busy_o",       32'(busy_o),       32'(m_busy()));
            check("pending_o",    32'(pending_o),    32'(m_q.size()));
            check("timeout_o",    32'(timeout_o),    32'(e_tmo));
            check("dead_count_o", dead_count_o,      e_dead);
            check("trig_lost_o",  32'(trig_lost_o),  32'(e_lost));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_event(input logic [31:0] info, output logic [31:0] b);
        trig_info = info;
        trig_type = info[0];
        trig = 1'b1;
        tick();
        trig = 1'b0;
        b = 32'(dig_buf_o);
        tick();
        dig_done = 1'b1;
        tick();
        dig_done = 1'b0;
        tick();
    endtask

    task automatic finish_dig();
        tick();
        dig_done = 1'b1;
        tick();
        dig_done = 1'b0;
        tick();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        logic [31:0] got_buf;
        int k;

        repeat (3) tick();
        check("reset_pending", 32'(pending_o), 32'd0);
        check("reset_busy",    32'(busy_o),    32'd0);
        check("reset_dead",    dead_count_o,   32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (3) tick();

        // Single trigger with late dig_done
        trig_info = 32'hDEADBEEF;
        trig_type = 1'b1;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("r42_event",   32'(event_o),     32'd1);
        check("r42_start",   32'(dig_start_o), 32'd1);
        check("r42_buf",     32'(dig_buf_o),   32'd0);
        check("r42_info",    event_info_o,     32'hDEADBEEF);
        check("r42_pending", 32'(pending_o),   32'd1);
        repeat (9) tick();
        dig_done = 1'b1;
        tick();
        dig_done = 1'b0;
        k = 0;
        repeat (4) begin
            tick();
            if (event_done_o) k++;
        end
        check("r42_done_count", 32'(k), 32'd1);
        do_flush();
        check("flush_pending", 32'(pending_o), 32'd0);

        // Fill all buffers, then overflow
        for (int i = 0; i < NBUF; i++) begin
            do_event(32'h1000 + 32'(i), got_buf);
            check("r43_buf", got_buf, 32'(i));
        end
        check("r43_full_pending", 32'(pending_o), 32'd4);
        check("r43_full_busy",    32'(busy_o),    32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("r43_clear_dead", dead_count_o, 32'd0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("r43_lost",      32'(trig_lost_o), 32'd1);
        check("r43_no_event",  32'(event_o),     32'd0);
        repeat (2) tick();
        check("r43_dead", dead_count_o, 32'd3);
        readout = 1'b1;
        tick();
        readout = 1'b0;
        check("r43_after_rd_pending", 32'(pending_o), 32'd3);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("r43_reaccept_event", 32'(event_o),   32'd1);
        check("r43_reaccept_buf",   32'(dig_buf_o), 32'd0);
        finish_dig();
        do_flush();

        // Timeout path
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("r44_start", 32'(dig_start_o), 32'd1);
        k = 0;
        while (!event_done_o && k < 200) begin
            tick();
            k++;
        end
        check("r44_done_latency", 32'(k), 32'(TMO + 2));
        check("r44_timeout",      32'(timeout_o), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("r44_timeout_clr", 32'(timeout_o), 32'd0);

        // Accept coinciding with readout, and readout on empty
        do_event(32'h2222, got_buf);
        check("r45_pending2", 32'(pending_o), 32'd2);
        trig = 1'b1;
        readout = 1'b1;
        tick();
        trig = 1'b0;
        readout = 1'b0;
        check("r45_pending_same", 32'(pending_o), 32'd2);
        check("r45_event",        32'(event_o),   32'd1);
        finish_dig();
        readout = 1'b1;
        repeat (3) tick();
        readout = 1'b0;
        check("r45_pending_empty", 32'(pending_o), 32'd0);

        // Flush in the middle of a digitization
        do_event(32'h3333, got_buf);
        do_event(32'h4444, got_buf);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("r46_pending3", 32'(pending_o), 32'd3);
        repeat (2) tick();
        do_flush();
        check("r46_pending0", 32'(pending_o), 32'd0);
        check("r46_busy",     32'(busy_o),    32'd0);
        k = 0;
        repeat (4) begin
            if (event_done_o) k++;
            tick();
        end
        check("r46_no_done", 32'(k), 32'd0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("r46_buf", 32'(dig_buf_o), 32'd0);
        finish_dig();
        do_flush();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            enable    = ($urandom_range(0, 9) != 0);
            trig      = ($urandom_range(0, 2) == 0);
            trig_type = 1'($urandom_range(0, 1));
            trig_info = $urandom();
            dig_done  = ($urandom_range(0, 11) == 0);
            readout   = ($urandom_range(0, 11) == 0);
            flush     = ($urandom_range(0, 249) == 0);
            clear     = ($urandom_range(0, 199) == 0);
            tick();
        end
        trig = 1'b0; dig_done = 1'b0; readout = 1'b0; flush = 1'b0; clear = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/radiant_event_buf_sched.md
RADIANT_EVENT_BUF_SCHED -- requirements
Module: radiant_event_buf_sched

Interface
REQ-001 Parameter NBUF, default 4: number of digitizer buffers; power of 2, 2..8.
REQ-002 Parameter DIG_TIMEOUT, default 4095: maximum cycles in DIGITIZE before forced completion.
REQ-003 Single clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  sys_clk domain clock; every port is synchronous to it.
REQ-005 rst_n_i  input  1  asynchronous active-low reset.
REQ-006 enable_i  input  1  trigger acceptance enable.
REQ-007 trig_i  input  1  single-cycle trigger request.
REQ-008 trig_type_i  input  1  trigger type.
REQ-009 trig_info_i  input  32  trigger info word.
REQ-010 dig_done_i  input  1  single-cycle digitization-complete pulse.
REQ-011 readout_done_i  input  1  single-cycle pulse: oldest buffer fully read out.
REQ-012 flush_i  input  1  free all buffers, abort activity (tied to event FIFO reset).
REQ-013 clear_stats_i  input  1  clear statistics counters.
REQ-014 dig_start_o  output  1  single-cycle digitize start pulse.
REQ-015 dig_buf_o  output  log2(NBUF)  buffer index being digitized.
REQ-016 event_o, event_type_o, event_info_o  output  1/1/32  event capture strobe plus latched type/info (to event control).
REQ-017 event_done_o  output  1  single-cycle event-complete pulse (to DMA request FIFO).
REQ-018 busy_o  output  1  triggers are not being accepted.
REQ-019 pending_o  output  log2(NBUF)+1  occupied buffer count.
REQ-020 timeout_o  output  1  sticky: a digitization timed out.
REQ-021 dead_count_o  output  32  cycles with enable_i high and busy_o high.
REQ-022 trig_lost_o  output  16  triggers dropped while busy.

Function
REQ-023 FSM states: IDLE, DIGITIZE, DONE.
REQ-024 Accept condition: state IDLE, trig_i=1, enable_i=1, pending<NBUF, flush_i=0.
REQ-025 Accept at cycle N -> cycle N+1: event_o=1, dig_start_o=1, dig_buf_o=wr_ptr, event_type_o/event_info_o = values sampled at N, state DIGITIZE, pending+1.
REQ-026 event_type_o, event_info_o, dig_buf_o hold until the next accept.
REQ-027 DIGITIZE: dig_done_i=1 or timer reaching DIG_TIMEOUT -> DONE next cycle; on timeout, timeout_o set.
REQ-028 Timer clears on entry to DIGITIZE and increments each DIGITIZE cycle.
REQ-029 DONE, one cycle: event_done_o=1, wr_ptr+1 mod NBUF, then IDLE; a trigger arriving in DONE is not accepted.
REQ-030 dig_done_i outside DIGITIZE is ignored.
REQ-031 readout_done_i with pending>0: pending-1, rd_ptr+1 mod NBUF. With pending=0: ignored.
REQ-032 Accept and readout_done_i in the same cycle: pending unchanged, both pointers update normally.
REQ-033 busy_o = (state!=IDLE) or (pending==NBUF), combinational.
REQ-034 dead_count_o increments when enable_i=1 and busy_o=1; wraps modulo 2^32.
REQ-035 trig_lost_o increments on trig_i=1, enable_i=1, busy_o=1; saturates at 0xFFFF.
REQ-036 trig_i with enable_i=0: no action, no count.
REQ-037 flush_i in any state, next cycle: state IDLE, pending=0, wr_ptr=rd_ptr=0, all pulses 0, no event_done_o for the aborted event; flush_i has priority over all other inputs.
REQ-038 clear_stats_i clears dead_count_o, trig_lost_o, and timeout_o next cycle; it has priority over increments.
REQ-039 All outputs except busy_o are registered.

Reset
REQ-040 rst_n_i low: state IDLE, all outputs and counters 0, pointers 0, timer 0.
REQ-041 Deassertion of rst_n_i is synchronized to clk_i; no accept is made in the first cycle after release.

Verification
REQ-042 Single trigger, info 0xDEADBEEF, dig_done_i 10 cycles later -> event_o/dig_start_o at N+1, dig_buf_o=0, event_info_o=0xDEADBEEF, event_done_o once, pending_o=1.
REQ-043 Five triggers with NBUF=4 and no readout -> four events with dig_buf 0,1,2,3; fifth trigger -> trig_lost_o=1, busy_o=1, dead_count_o counting; one readout_done_i -> next trigger accepted with dig_buf_o=0.
REQ-044 dig_done_i never asserted -> event_done_o at DIG_TIMEOUT+2 cycles after start, timeout_o=1; clear_stats_i -> timeout_o=0.
REQ-045 Accept coinciding with readout_done_i at pending=2 -> pending_o stays 2; readout_done_i at pending=0 -> pending_o stays 0.
REQ-046 flush_i mid-DIGITIZE with pending=3 -> pending_o=0, state IDLE, no event_done_o; the next trigger gets dig_buf_o=0.
